// File: rtl/led_pkg.sv
// led_pkg: shared types and constants for the LED key front end.
//   key_state_e   - per-key debounce FSM state
//   NUM_MODES_DEF - default number of LED modes
//   KEY_NEXT/PREV - bit positions of the NEXT and PREV keys in key_n
package led_pkg;
    localparam int NUM_MODES_DEF = 4;
    localparam int KEY_NEXT = 0;
    localparam int KEY_PREV = 1;
    typedef enum logic [2:0] {
        RELEASED,
        DEB_PRESS,
        HELD,
        LONG,
        DEB_RELEASE
    } key_state_e;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronise, debounce and classify one active-low key.
//   clk, rst_n   - clock, async active-low reset
//   key_n_i      - raw asynchronous key level, active-low
//   short_evt_o  - one-cycle pulse when a short press is released
//   long_evt_o   - one-cycle pulse when a held press becomes long
module key_debounce
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 20000,
    parameter int LONG_PRESS_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic short_evt_o,
    output logic long_evt_o
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

    key_state_e    state_q, state_d;
    logic [1:0]    sync_q;
    logic [DW-1:0] db_q, db_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          from_long_q, from_long_d;
    logic          short_q, short_d, long_q, long_d;
    logic          lvl, db_done, hold_done;

    assign lvl = sync_q[1];
    // The sample that triggers entry into a debounce state is the first of
    // the DEBOUNCE_CYCLES stable samples, so the counter stops two short.
    assign db_done   = db_q >= DW'(DEBOUNCE_CYCLES - 2);
    assign hold_done = hold_q >= HW'(LONG_PRESS_CYCLES - 1);
    assign short_evt_o = short_q;
    assign long_evt_o  = long_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            state_q     <= RELEASED;
            db_q        <= '0;
            hold_q      <= '0;
            from_long_q <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], key_n_i};
            state_q     <= state_d;
            db_q        <= db_d;
            hold_q      <= hold_d;
            from_long_q <= from_long_d;
            short_q     <= short_d;
            long_q      <= long_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RELEASED:    state_d = lvl ? RELEASED : DEB_PRESS;
            DEB_PRESS:   state_d = lvl ? RELEASED : (db_done ? HELD : DEB_PRESS);
            HELD:        state_d = lvl ? DEB_RELEASE : (hold_done ? LONG : HELD);
            LONG:        state_d = lvl ? DEB_RELEASE : LONG;
            DEB_RELEASE: state_d = !lvl ? (from_long_q ? LONG : HELD)
                                        : (db_done ? RELEASED : DEB_RELEASE);
            default:     state_d = RELEASED;
        endcase
    end

    always_comb begin
        db_d        = (state_d != state_q) ? '0 : (db_done ? db_q : db_q + DW'(1));
        hold_d      = (state_d == HELD && state_q != HELD) ? '0
                    : (hold_done ? hold_q : hold_q + HW'(1));
        from_long_d = (state_q == LONG) ? 1'b1 : (state_q == HELD) ? 1'b0 : from_long_q;
        short_d     = state_q == DEB_RELEASE && state_d == RELEASED && !from_long_q;
        long_d      = state_q == HELD && state_d == LONG;
    end
endmodule

// File: rtl/led_key_ctrl.sv
// led_key_ctrl: turn NEXT/PREV key presses into LED mode index and enable.
//   clk, rst_n   - clock, async active-low reset
//   key_n        - raw keys, active-low; [0]=NEXT, [1]=PREV
//   mode         - current LED mode index
//   mode_changed - one-cycle pulse coincident with a new mode value
//   led_en       - LED pattern enable, toggled by a long NEXT press
//   key_evt      - one-cycle short-press pulse per key
module led_key_ctrl
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 20000,
    parameter int LONG_PRESS_CYCLES = 1000000,
    parameter int NUM_MODES         = NUM_MODES_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   key_n,
    output logic [$clog2(NUM_MODES)-1:0] mode,
    output logic                         mode_changed,
    output logic                         led_en,
    output logic [1:0]                   key_evt
);
    localparam int MW = $clog2(NUM_MODES);

    logic [1:0]    short_evt, long_evt;
    logic [MW-1:0] mode_q, mode_d, mode_inc, mode_dec;
    logic          mc_q, mc_d, led_en_q, led_en_d;
    logic [1:0]    key_evt_q;

    for (genvar k = 0; k < 2; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_key (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_n_i    (key_n[k]),
            .short_evt_o(short_evt[k]),
            .long_evt_o (long_evt[k])
        );
    end

    // Opposing short steps cancel; a long PREV reset wins over any step.
    always_comb begin
        mode_inc = (mode_q == MW'(NUM_MODES - 1)) ? '0 : mode_q + MW'(1);
        mode_dec = (mode_q == '0) ? MW'(NUM_MODES - 1) : mode_q - MW'(1);
        mode_d   = long_evt[KEY_PREV] ? '0
                 : (short_evt == 2'b01 << KEY_NEXT) ? mode_inc
                 : (short_evt == 2'b01 << KEY_PREV) ? mode_dec : mode_q;
        mc_d     = mode_d != mode_q;
        led_en_d = led_en_q ^ long_evt[KEY_NEXT];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= '0;
            mc_q      <= 1'b0;
            led_en_q  <= 1'b1;
            key_evt_q <= 2'b00;
        end else begin
            mode_q    <= mode_d;
            mc_q      <= mc_d;
            led_en_q  <= led_en_d;
            key_evt_q <= short_evt;
        end
    end

    assign mode         = mode_q;
    assign mode_changed = mc_q;
    assign led_en       = led_en_q;
    assign key_evt      = key_evt_q;
endmodule

// File: tb/tb_led_key_ctrl.sv
// tb_led_key_ctrl: directed self-checking bench for led_key_ctrl.
module tb_led_key_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] key_n = 2'b11;
    logic [1:0] mode;
    logic       mode_changed, led_en;
    logic [1:0] key_evt;

    int tests = 0, fails = 0;
    int n_next = 0, n_prev = 0, n_both = 0, n_mc = 0, n_tog = 0;
    int width_err = 0, coh_err = 0;
    int s_next, s_prev, s_both, s_mc, s_tog;
    logic [1:0] p_mode = 2'b00, p_evt = 2'b00;
    logic       p_mc = 1'b0, p_led = 1'b1;

    led_key_ctrl #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(16),
        .NUM_MODES        (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_n),
        .mode        (mode),
        .mode_changed(mode_changed),
        .led_en      (led_en),
        .key_evt     (key_evt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            n_next += (key_evt == 2'b01) ? 1 : 0;
            n_prev += (key_evt == 2'b10) ? 1 : 0;
            n_both += (key_evt == 2'b11) ? 1 : 0;
            n_mc   += mode_changed ? 1 : 0;
            n_tog  += (led_en != p_led) ? 1 : 0;
            width_err += (((key_evt & p_evt) != 2'b00) || (mode_changed && p_mc)) ? 1 : 0;
            coh_err   += ((mode != p_mode) != mode_changed) ? 1 : 0;
        end
        p_mode = mode;
        p_evt  = key_evt;
        p_mc   = mode_changed;
        p_led  = led_en;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        s_next = n_next; s_prev = n_prev; s_both = n_both; s_mc = n_mc; s_tog = n_tog;
    endtask

    task automatic press(input logic [1:0] keys, input int hold);
        key_n = ~keys;
        cyc(hold);
        key_n = 2'b11;
        cyc(12);
    endtask

    initial begin
        cyc(3);
        chk("rst_mode", mode, 0);
        chk("rst_led_en", led_en, 1);
        chk("rst_mc", mode_changed, 0);
        chk("rst_key_evt", key_evt, 0);
        rst_n = 1'b1;
        cyc(3);

        snap();
        key_n[0] = 1'b0;
        cyc(8);
        key_n[0] = 1'b1;
        cyc(6);
        chk("short_lat_evt_early", key_evt, 0);
        chk("short_lat_mode_early", mode, 0);
        cyc(1);
        chk("short_lat_evt", key_evt, 1);
        chk("short_lat_mode", mode, 1);
        chk("short_lat_mc", mode_changed, 1);
        cyc(1);
        chk("short_evt_width", key_evt, 0);
        chk("short_mc_width", mode_changed, 0);
        cyc(10);
        press(2'b01, 8);
        chk("next_mode2", mode, 2);
        press(2'b01, 8);
        chk("next_mode3", mode, 3);
        press(2'b01, 8);
        chk("next_wrap0", mode, 0);
        chk("next_evt_cnt", n_next - s_next, 4);
        chk("next_mc_cnt", n_mc - s_mc, 4);

        snap();
        for (int i = 0; i < 10; i++) begin
            key_n[0] = i[0];
            cyc(2);
        end
        key_n[0] = 1'b1;
        cyc(12);
        chk("bounce_evt", n_next - s_next, 0);
        chk("bounce_mode", mode, 0);

        snap();
        press(2'b10, 8);
        chk("prev_wrap_mode", mode, 3);
        chk("prev_wrap_evt", n_prev - s_prev, 1);

        snap();
        press(2'b01, 30);
        chk("long1_led_en", led_en, 0);
        chk("long1_mode", mode, 3);
        chk("long1_no_short", n_next - s_next, 0);
        chk("long1_tog", n_tog - s_tog, 1);
        press(2'b01, 30);
        chk("long2_led_en", led_en, 1);

        press(2'b10, 8);
        chk("prev_mode2", mode, 2);
        snap();
        press(2'b11, 8);
        chk("simul_mode", mode, 2);
        chk("simul_mc", n_mc - s_mc, 0);
        chk("simul_evt11", n_both - s_both, 1);
        snap();
        press(2'b10, 30);
        chk("long_prev_mode", mode, 0);
        chk("long_prev_mc", n_mc - s_mc, 1);
        chk("long_prev_no_short", n_prev - s_prev, 0);

        press(2'b10, 8);
        press(2'b01, 30);
        chk("pre_rst_mode", mode, 3);
        chk("pre_rst_led_en", led_en, 0);
        key_n[0] = 1'b0;
        cyc(10);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_mode", mode, 0);
        chk("rst_async_led_en", led_en, 1);
        cyc(2);
        rst_n = 1'b1;
        cyc(22);
        chk("rst_reheld_pre_long", led_en, 1);
        cyc(1);
        chk("rst_reheld_long", led_en, 0);
        snap();
        key_n[0] = 1'b1;
        cyc(12);
        chk("rst_release_no_short", n_next - s_next, 0);
        chk("rst_release_mode", mode, 0);

        chk("pulse_width", width_err, 0);
        chk("mc_coherent", coh_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
